// File: rtl/mul_seq32_ctrl.sv
// Sequential 32x32 unsigned shift-add multiplier that reuses one 32-bit adder over 32 cycles.
// Optional macro MUL_ABORT_EN adds an abort_i input that cancels an operation in CALC or DONE.

module fulladder32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        carry_i,
  output logic [31:0] sum_o,
  output logic        carry_o
);

  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'h0, carry_i};

endmodule

module mul_seq32_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef MUL_ABORT_EN
  input  logic        abort_i,
`endif
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] prod_lo_o,
  output logic [31:0] prod_hi_o,
  output logic        busy_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] mcand;
  logic [63:0] prod;

  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic        add_carry;
  logic        abort;

`ifdef MUL_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  // Partial product lives in prod[63:32]; the multiplier bits drain out of prod[31:0].
  assign add_b = prod[0] ? mcand : 32'h0;

  fulladder32 u_adder (
    .a_i     (prod[63:32]),
    .b_i     (add_b),
    .carry_i (1'b0),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, which keeps the shift and the add in lockstep.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      cnt   <= 5'd0;
      mcand <= 32'h0;
      prod  <= 64'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            mcand <= a_i;
            prod  <= {32'h0, b_i};
            cnt   <= 5'd0;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            // Adder carry lands in bit 63 after the right shift, so no bit is lost.
            prod <= {add_carry, add_sum, prod[31:1]};
            cnt  <= cnt + 5'd1;
            if (cnt == 5'd31) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (abort || ready_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs depend on state alone, never combinationally on inputs.
  assign ready_o   = (state == ST_IDLE);
  assign valid_o   = (state == ST_DONE);
  assign busy_o    = (state == ST_CALC) || (state == ST_DONE);
  assign prod_lo_o = prod[31:0];
  assign prod_hi_o = prod[63:32];

endmodule

// File: tb/tb_mul_seq32_ctrl.sv
// Randomized self-checking bench for mul_seq32_ctrl against a plain a*b reference.
// Define MUL_ABORT_EN on both bench and RTL to exercise the abort feature.

module tb_mul_seq32_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        abort_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] prod_lo_o;
  logic [31:0] prod_hi_o;
  logic        busy_o;

  int nvec = 0;
  int nerr = 0;

  always #5 clk_i = ~clk_i;

  mul_seq32_ctrl dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
`ifdef MUL_ABORT_EN
    .abort_i   (abort_i),
`endif
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .a_i       (a_i),
    .b_i       (b_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .prod_lo_o (prod_lo_o),
    .prod_hi_o (prod_hi_o),
    .busy_o    (busy_o)
  );

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    return {32'h0, a} * {32'h0, b};
  endfunction

  task automatic test_reset;
    rst_i = 1'b1; abort_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    a_i = 32'h0; b_i = 32'h0;
    tick; tick;
    nvec++;
    if ({ready_o, valid_o, busy_o} !== 3'b100 || {prod_hi_o, prod_lo_o} !== 64'h0) begin
      nerr++;
      $display("FAIL reset: rdy/vld/busy=%b prod=%h, want 100 prod=0",
               {ready_o, valid_o, busy_o}, {prod_hi_o, prod_lo_o});
    end
    rst_i = 1'b0;
    tick;
  endtask

  // One full operation: accept, check 32-cycle latency, stall in DONE, release.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int stall, input string name);
    logic [63:0] exp_p;
    int n;
    exp_p = ref_mul(a, b);
    n = 0;
    while (!ready_o && n < 50) begin tick; n++; end
    a_i = a; b_i = b; valid_i = 1'b1; ready_i = 1'b0;
    tick;
    valid_i = 1'b0;
    nvec++;
    if (busy_o !== 1'b1 || ready_o !== 1'b0 || valid_o !== 1'b0) begin
      nerr++;
      $display("FAIL %s accept: busy=%b ready=%b valid=%b, want 1 0 0", name, busy_o, ready_o, valid_o);
    end
    n = 0;
    while (valid_o !== 1'b1 && n < 40) begin
      a_i = $urandom; b_i = $urandom; valid_i = 1'($urandom);
      tick; n++;
    end
    nvec++;
    if (n != 32) begin
      nerr++;
      $display("FAIL %s latency: %0d cycles, want 32", name, n);
    end
    nvec++;
    if ({prod_hi_o, prod_lo_o} !== exp_p) begin
      nerr++;
      $display("FAIL %s product: got %h, want %h", name, {prod_hi_o, prod_lo_o}, exp_p);
    end
    for (int i = 0; i < stall; i++) begin
      a_i = $urandom; b_i = $urandom; valid_i = 1'($urandom);
      tick;
      nvec++;
      if (valid_o !== 1'b1 || ready_o !== 1'b0 || {prod_hi_o, prod_lo_o} !== exp_p) begin
        nerr++;
        $display("FAIL %s stall %0d: valid=%b ready=%b prod=%h, want 1 0 %h",
                 name, i, valid_o, ready_o, {prod_hi_o, prod_lo_o}, exp_p);
      end
    end
    valid_i = 1'b0; ready_i = 1'b1;
    tick;
    ready_i = 1'b0;
    nvec++;
    if ({ready_o, valid_o, busy_o} !== 3'b100 || {prod_hi_o, prod_lo_o} !== exp_p) begin
      nerr++;
      $display("FAIL %s release: rdy/vld/busy=%b prod=%h, want 100 prod=%h",
               name, {ready_o, valid_o, busy_o}, {prod_hi_o, prod_lo_o}, exp_p);
    end
  endtask

  task automatic test_directed;
    run_op(32'h3, 32'h5, 0, "3x5");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "max_x_max");
    run_op(32'h8000_0000, 32'h2, 0, "msb_x_2");
    run_op(32'h0, 32'h1234_5678, 0, "zero_x_n");
  endtask

  task automatic test_done_stall;
    run_op(32'hCAFE_F00D, 32'h1357_9BDF, 10, "stall10");
  endtask

  task automatic test_reset_mid;
    a_i = 32'hDEAD_BEEF; b_i = 32'h0BAD_F00D; valid_i = 1'b1;
    tick;
    valid_i = 1'b0;
    for (int i = 0; i < 9; i++) tick;
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    nvec++;
    if ({ready_o, valid_o, busy_o} !== 3'b100 || {prod_hi_o, prod_lo_o} !== 64'h0) begin
      nerr++;
      $display("FAIL reset_mid: rdy/vld/busy=%b prod=%h, want 100 prod=0",
               {ready_o, valid_o, busy_o}, {prod_hi_o, prod_lo_o});
    end
    for (int i = 0; i < 40; i++) begin
      tick;
      if (valid_o !== 1'b0) begin
        nvec++; nerr++;
        $display("FAIL reset_mid ghost: valid=%b at cycle %0d, want 0", valid_o, i);
        break;
      end
    end
    run_op(32'd7, 32'd6, 0, "7x6_after_reset");
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, b;
      a = (i == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      b = 32'($urandom);
      run_op(a, b, int'($urandom_range(0, 3)), "random");
    end
  endtask

  // valid_i and ready_i held high: one operation every 34 cycles, products in order.
  task automatic test_back_to_back;
    logic [63:0] q[$];
    logic [63:0] exp_p;
    int last_acc, cyc, done;
    logic acc;
    last_acc = -1; cyc = 0; done = 0;
    ready_i = 1'b1; valid_i = 1'b1; a_i = $urandom; b_i = $urandom;
    while (done < 3 && cyc < 200) begin
      if (valid_o === 1'b1) begin
        exp_p = (q.size() > 0) ? q.pop_front() : 64'hX;
        nvec++;
        if ({prod_hi_o, prod_lo_o} !== exp_p) begin
          nerr++;
          $display("FAIL b2b product %0d: got %h, want %h", done, {prod_hi_o, prod_lo_o}, exp_p);
        end
        done++;
      end
      acc = (ready_o === 1'b1);
      if (acc) begin
        q.push_back(ref_mul(a_i, b_i));
        if (last_acc >= 0) begin
          nvec++;
          if (cyc - last_acc != 34) begin
            nerr++;
            $display("FAIL b2b spacing: %0d cycles, want 34", cyc - last_acc);
          end
        end
        last_acc = cyc;
      end
      tick; cyc++;
      if (acc) begin a_i = $urandom; b_i = $urandom; end
    end
    if (done < 3) begin
      nvec++; nerr++;
      $display("FAIL b2b timeout: %0d products seen, want 3", done);
    end
    valid_i = 1'b0; ready_i = 1'b0;
    for (int i = 0; i < 40 && !ready_o; i++) begin ready_i = 1'b1; tick; end
    ready_i = 1'b0;
  endtask

`ifdef MUL_ABORT_EN
  task automatic test_abort;
    a_i = 32'h1234_5678; b_i = 32'h9ABC_DEF0; valid_i = 1'b1;
    tick;
    valid_i = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    abort_i = 1'b1;
    tick;
    abort_i = 1'b0;
    nvec++;
    if ({ready_o, valid_o, busy_o} !== 3'b100) begin
      nerr++;
      $display("FAIL abort: rdy/vld/busy=%b, want 100", {ready_o, valid_o, busy_o});
    end
    for (int i = 0; i < 40; i++) begin
      tick;
      if (valid_o !== 1'b0) begin
        nvec++; nerr++;
        $display("FAIL abort ghost: valid=%b at cycle %0d, want 0", valid_o, i);
        break;
      end
    end
    run_op(32'h0001_0000, 32'h0001_0000, 0, "after_abort");
  endtask
`endif

  initial begin
    test_reset;
    test_directed;
    test_done_stall;
    test_reset_mid;
    test_random;
    test_back_to_back;
`ifdef MUL_ABORT_EN
    test_abort;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
